// File: rtl/avalon_mm_pipelined_responder_pkg.sv
// Shared widths and helpers for the pipelined Avalon-MM responder.
package avalon_mm_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int WORD_IDX_W = 6;
    localparam int NUM_WORDS  = 1 << WORD_IDX_W;

    // Byte address to word index; the two low bits select a byte and are ignored.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2];
    endfunction

    // Lane-masked write: enabled byte lanes take the incoming data, others keep the old value.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] wr_data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_data;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/avalon_mm_pipelined_responder_if.sv
// Avalon-MM pipelined bus bundle between the bridge master port and the responder.
interface avalon_mm_pipelined_responder_if;
    import avalon_mm_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              endofpacket;
    logic              waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, readdatavalid, endofpacket, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, readdatavalid, endofpacket, waitrequest
    );

endinterface

// File: rtl/avalon_mm_pipelined_responder_rd_latency_pipe.sv
// Fixed-latency read response pipeline. The last stage is the registered bus
// output; its data/eop only load on a valid entry, so they hold between responses.
module rd_latency_pipe
    import avalon_mm_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_eop,
    output logic [DATA_W-1:0] out_data,
    output logic              retire
);

    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  eop_reg;
    logic [DATA_W-1:0] data_reg [DEPTH];

    // Shift valid every cycle (no stall possible); payload moves only with a valid entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            eop_reg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg[0] <= in_valid;
            if (in_valid) begin
                eop_reg[0]  <= in_eop;
                data_reg[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                if (valid_reg[i-1]) begin
                    eop_reg[i]  <= eop_reg[i-1];
                    data_reg[i] <= data_reg[i-1];
                end
            end
        end
    end

    // A response retires on the edge that loads the output stage.
    generate
        if (DEPTH == 1) begin : g_retire_direct
            assign retire = in_valid;
        end else begin : g_retire_staged
            assign retire = valid_reg[DEPTH-2];
        end
    endgenerate

    assign out_valid = valid_reg[DEPTH-1];
    assign out_eop   = eop_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/avalon_mm_pipelined_responder.sv
// Avalon-MM pipelined responder: 64x32 register file with byte-enable writes,
// fixed-latency reads and waitrequest bounding the outstanding read count.
module avalon_mm_pipelined_responder
    import avalon_mm_pkg::*;
#(
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 2,
    parameter int EOP_WORD     = 63
) (
    input  logic                           clk,
    input  logic                           reset,
    avalon_mm_pipelined_responder_if.slave bus
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    logic [DATA_W-1:0]     mem_reg [NUM_WORDS];
    logic [PEND_W-1:0]     pending_reg;
    logic [WORD_IDX_W-1:0] word;
    logic                  stall;
    logic                  accept_rd;
    logic                  accept_wr;
    logic                  rd_eop;
    logic                  retire;
    logic                  pipe_valid;
    logic                  pipe_eop;
    logic [DATA_W-1:0]     pipe_data;

    assign word      = word_index(bus.address);
    // Stall depends only on the registered count, so no path from read/write.
    assign stall     = (pending_reg == PEND_W'(MAX_PENDING));
    assign accept_wr = bus.write & ~stall;
    // A read coinciding with a write is dropped; the write wins.
    assign accept_rd = bus.read & ~bus.write & ~stall;
    assign rd_eop    = (word == WORD_IDX_W'(EOP_WORD));

    // Register file with per-lane write enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (accept_wr) begin
            mem_reg[word] <= be_merge(mem_reg[word], bus.writedata, bus.byteenable);
        end
    end

    // Outstanding read count: up on acceptance, down when a response is driven out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else if (accept_rd && !retire) begin
            pending_reg <= pending_reg + PEND_W'(1);
        end else if (!accept_rd && retire) begin
            pending_reg <= pending_reg - PEND_W'(1);
        end
    end

    // Read data is snapshotted here at acceptance, so later writes cannot alter it.
    rd_latency_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept_rd),
        .in_eop    (rd_eop),
        .in_data   (mem_reg[word]),
        .out_valid (pipe_valid),
        .out_eop   (pipe_eop),
        .out_data  (pipe_data),
        .retire    (retire)
    );

    assign bus.waitrequest   = stall;
    assign bus.readdatavalid = pipe_valid;
    assign bus.endofpacket   = pipe_eop;
    assign bus.readdata      = pipe_data;

endmodule

// File: tb/tb_avalon_mm_pipelined_responder.sv
// Bench for avalon_mm_pipelined_responder: two instances (MAX_PENDING 2 and 3),
// a timeline-based reference model, a per-cycle compare and directed literal checks.
module tb_avalon_mm_pipelined_responder;

    localparam int L   = 3;
    localparam int MP0 = 2;
    localparam int MP1 = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    avalon_mm_pipelined_responder_if b0();
    avalon_mm_pipelined_responder_if b1();

    avalon_mm_pipelined_responder #(.READ_LATENCY(L), .MAX_PENDING(MP0), .EOP_WORD(63)) dut0 (
        .clk(clk), .reset(reset), .bus(b0));
    avalon_mm_pipelined_responder #(.READ_LATENCY(L), .MAX_PENDING(MP1), .EOP_WORD(63)) dut1 (
        .clk(clk), .reset(reset), .bus(b1));

    // Per-instance command drive
    logic [7:0]  addr_s [2];
    logic [3:0]  be_s   [2];
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [31:0] wd_s   [2];

    assign b0.address = addr_s[0];  assign b1.address = addr_s[1];
    assign b0.byteenable = be_s[0]; assign b1.byteenable = be_s[1];
    assign b0.read = rd_s[0];       assign b1.read = rd_s[1];
    assign b0.write = wr_s[0];      assign b1.write = wr_s[1];
    assign b0.writedata = wd_s[0];  assign b1.writedata = wd_s[1];

    logic        o_wait [2];
    logic        o_rdv  [2];
    logic        o_eop  [2];
    logic [31:0] o_data [2];

    assign o_wait[0] = b0.waitrequest;   assign o_wait[1] = b1.waitrequest;
    assign o_rdv[0]  = b0.readdatavalid; assign o_rdv[1]  = b1.readdatavalid;
    assign o_eop[0]  = b0.endofpacket;   assign o_eop[1]  = b1.endofpacket;
    assign o_data[0] = b0.readdata;      assign o_data[1] = b1.readdata;

    // Reference model: memory image plus a timeline of scheduled responses.
    int          mp_m [2];
    logic [31:0] mem_m [2][64];
    bit          sched_v [2][16];
    logic [31:0] sched_d [2][16];
    bit          sched_e [2][16];
    int          pend_m [2];
    logic [31:0] last_d [2];
    bit          last_e [2];
    bit          exp_rdv [2];
    int          edge_n;

    // Bench bookkeeping
    int          vectors;
    int          miscompares;
    int          cyc_n;
    int          rdv_cnt [2];
    int          wait_cnt [2];
    logic [31:0] rsp_data [2];
    logic        rsp_eop [2];

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) mem_m[d][w] = 32'h0;
            for (int s = 0; s < 16; s++) begin
                sched_v[d][s] = 1'b0;
                sched_d[d][s] = 32'h0;
                sched_e[d][s] = 1'b0;
            end
            pend_m[d]  = 0;
            last_d[d]  = 32'h0;
            last_e[d]  = 1'b0;
            exp_rdv[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            logic [7:0]  a;
            logic [31:0] cur;
            logic [31:0] wd;
            logic [3:0]  be;
            int          w;
            int          slot;
            bit          stalled, acc_rd, acc_wr, ret;
            a       = addr_s[d];
            w       = int'(a) / 4;
            stalled = (pend_m[d] >= mp_m[d]);
            acc_wr  = wr_s[d] && !stalled;
            acc_rd  = rd_s[d] && !wr_s[d] && !stalled;
            if (acc_rd) begin
                slot = (edge_n + L - 1) % 16;
                sched_v[d][slot] = 1'b1;
                sched_d[d][slot] = mem_m[d][w];
                sched_e[d][slot] = (w == 63);
            end
            slot = edge_n % 16;
            ret  = sched_v[d][slot];
            exp_rdv[d] = ret;
            if (ret) begin
                last_d[d] = sched_d[d][slot];
                last_e[d] = sched_e[d][slot];
                sched_v[d][slot] = 1'b0;
            end
            if (acc_wr) begin
                cur = mem_m[d][w];
                wd  = wd_s[d];
                be  = be_s[d];
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
                end
                mem_m[d][w] = cur;
            end
            pend_m[d] = pend_m[d] + int'(acc_rd) - int'(ret);
        end
        edge_n++;
    endtask

    initial begin
        mp_m[0] = MP0;
        mp_m[1] = MP1;
        edge_n  = 0;
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, act, exp, cyc_n);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check("waitrequest", d, 32'(o_wait[d]), 32'(pend_m[d] == mp_m[d]));
            check("readdatavalid", d, 32'(o_rdv[d]), 32'(exp_rdv[d]));
            check("readdata", d, o_data[d], last_d[d]);
            if (exp_rdv[d]) check("endofpacket", d, 32'(o_eop[d]), 32'(last_e[d]));
            if (o_rdv[d]) begin
                rdv_cnt[d]++;
                rsp_data[d] = o_data[d];
                rsp_eop[d]  = o_eop[d];
                $display("cyc %0d dut%0d response data=%h eop=%0d", cyc_n, d, o_data[d], o_eop[d]);
            end
            if (o_wait[d]) wait_cnt[d]++;
        end
    endtask

    // One clock cycle: compare on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic set_all(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        for (int d = 0; d < 2; d++) begin
            rd_s[d] = rd; wr_s[d] = wr; addr_s[d] = a; be_s[d] = be; wd_s[d] = wd;
        end
    endtask

    task automatic idle();
        set_all(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be);
        set_all(1'b0, 1'b1, a, be, wd);
        $display("cyc %0d write addr=%h data=%h be=%h", cyc_n, a, wd, be);
        tick();
        idle();
    endtask

    task automatic single_read(input string name, input logic [7:0] a,
                               input logic [31:0] exp_data, input logic exp_eop);
        int c0, c1, lat0, lat1;
        c0 = rdv_cnt[0];
        c1 = rdv_cnt[1];
        lat0 = 0;
        lat1 = 0;
        check({name, "_wait_at_issue"}, 0, 32'(o_wait[0]), 32'h0);
        set_all(1'b1, 1'b0, a, 4'h0, 32'h0);
        $display("cyc %0d read addr=%h", cyc_n, a);
        tick();
        idle();
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (lat0 == 0 && rdv_cnt[0] != c0) lat0 = n;
            if (lat1 == 0 && rdv_cnt[1] != c1) lat1 = n;
            if (lat0 != 0 && lat1 != 0) break;
        end
        check({name, "_latency"}, 0, 32'(lat0), 32'(L));
        check({name, "_latency"}, 1, 32'(lat1), 32'(L));
        check({name, "_data"}, 0, rsp_data[0], exp_data);
        check({name, "_data"}, 1, rsp_data[1], exp_data);
        check({name, "_eop"}, 0, 32'(rsp_eop[0]), 32'(exp_eop));
        check({name, "_eop"}, 1, 32'(rsp_eop[1]), 32'(exp_eop));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0, c1, wc1, first_wait_acc, done1_k, first1, last1, prev1, got_n;
        int          iss [2];
        bit          acc [2];
        logic [31:0] got [4];
        logic [7:0]  ra;

        vectors = 0; miscompares = 0; cyc_n = 0;
        for (int d = 0; d < 2; d++) begin
            rdv_cnt[d] = 0; wait_cnt[d] = 0; rsp_data[d] = 32'h0; rsp_eop[d] = 1'b0;
        end
        idle();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_wait", 0, 32'(o_wait[0]), 32'h0);
        check("reset_rdv", 1, 32'(o_rdv[1]), 32'h0);
        check("reset_data", 0, o_data[0], 32'h0);
        check("reset_eop", 0, 32'(o_eop[0]), 32'h0);

        // Basic write then read
        do_write(8'h10, 32'hDEADBEEF, 4'hF);
        single_read("basic", 8'h10, 32'hDEADBEEF, 1'b0);

        // Byte-enable merge
        do_write(8'h20, 32'hFFFFFFFF, 4'hF);
        do_write(8'h20, 32'h11223344, 4'h5);
        single_read("be_merge", 8'h20, 32'hFF22FF44, 1'b0);

        // Held read to words 0..5; master holds each address until accepted
        for (int i = 0; i < 6; i++) do_write(8'(i * 4), 32'h10000000 + 32'(i * 32'h111), 4'hF);
        c0 = rdv_cnt[0]; c1 = rdv_cnt[1]; wc1 = wait_cnt[1];
        iss[0] = 0; iss[1] = 0; first_wait_acc = -1; done1_k = -1;
        first1 = -1; last1 = -1;
        for (int k = 0; k < 40 && (iss[0] < 6 || iss[1] < 6); k++) begin
            for (int d = 0; d < 2; d++) begin
                rd_s[d] = (iss[d] < 6); wr_s[d] = 1'b0; addr_s[d] = 8'(iss[d] * 4);
            end
            if (o_wait[0] && first_wait_acc < 0) first_wait_acc = iss[0];
            for (int d = 0; d < 2; d++) acc[d] = rd_s[d] && !o_wait[d];
            prev1 = rdv_cnt[1];
            tick();
            if (rdv_cnt[1] != prev1) begin
                if (first1 < 0) first1 = cyc_n;
                last1 = cyc_n;
            end
            for (int d = 0; d < 2; d++) if (acc[d]) iss[d]++;
            if (iss[1] == 6 && done1_k < 0) done1_k = k;
        end
        idle();
        for (int n = 0; n < 8; n++) begin
            prev1 = rdv_cnt[1];
            tick();
            if (rdv_cnt[1] != prev1) begin
                if (first1 < 0) first1 = cyc_n;
                last1 = cyc_n;
            end
        end
        check("hold_acc_before_wait", 0, 32'(first_wait_acc), 32'd2);
        check("hold_responses", 0, 32'(rdv_cnt[0] - c0), 32'd6);
        check("hold_responses", 1, 32'(rdv_cnt[1] - c1), 32'd6);
        check("hold_no_wait", 1, 32'(wait_cnt[1] - wc1), 32'd0);
        check("hold_issue_cycles", 1, 32'(done1_k), 32'd5);
        check("hold_rsp_span", 1, 32'(last1 - first1), 32'd5);
        check("hold_last_data", 0, rsp_data[0], 32'h10000555);

        // End-of-packet tagging
        do_write(8'hFC, 32'hCAFEF00D, 4'hF);
        do_write(8'hF8, 32'h0BADC0DE, 4'hF);
        single_read("eop_word63", 8'hFC, 32'hCAFEF00D, 1'b1);
        single_read("eop_word62", 8'hF8, 32'h0BADC0DE, 1'b0);

        // Snapshot at acceptance: read, overwrite next cycle, read again
        do_write(8'h30, 32'hA5A5A5A5, 4'hF);
        c0 = rdv_cnt[0];
        set_all(1'b1, 1'b0, 8'h30, 4'h0, 32'h0); tick();
        set_all(1'b0, 1'b1, 8'h30, 4'hF, 32'h0); tick();
        set_all(1'b1, 1'b0, 8'h30, 4'h0, 32'h0); tick();
        idle();
        got_n = 0;
        for (int n = 0; n < 10 && got_n < 2; n++) begin
            prev1 = rdv_cnt[0];
            tick();
            if (rdv_cnt[0] != prev1) begin
                got[got_n] = rsp_data[0];
                got_n++;
            end
        end
        check("snapshot_count", 0, 32'(got_n), 32'd2);
        check("snapshot_old", 0, got[0], 32'hA5A5A5A5);
        check("snapshot_new", 0, got[1], 32'h0);

        // Reset with two reads in flight
        do_write(8'h10, 32'hDEADBEEF, 4'hF);
        c0 = rdv_cnt[0]; c1 = rdv_cnt[1];
        set_all(1'b1, 1'b0, 8'h10, 4'h0, 32'h0); tick();
        set_all(1'b1, 1'b0, 8'h14, 4'h0, 32'h0); tick();
        idle();
        reset = 1'b1;
        $display("cyc %0d reset pulse with reads in flight", cyc_n);
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check("reset_flush_rdv", 0, 32'(rdv_cnt[0] - c0), 32'd0);
        check("reset_flush_rdv", 1, 32'(rdv_cnt[1] - c1), 32'd0);
        check("reset_flush_wait", 0, 32'(o_wait[0]), 32'h0);
        single_read("reset_mem_cleared", 8'h10, 32'h0, 1'b0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 7) == 0) ? 8'hFC : 8'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            set_all($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, ra,
                    4'($urandom_range(0, 15)), $urandom);
            if (k % 150 == 149) begin
                reset = 1'b1;
                $display("cyc %0d random reset pulse", cyc_n);
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        idle();
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
